pixel_fb_writer: RTL and testbench

Receiving end of the pixel-write bus driven by the tile drawer and other pixel producers. Each cycle it samples `draw_enable`, `x`, `y` and the 24-bit colour, clips against the screen, and buffers accepted pixels in a small FIFO. It drains the FIFO into the framebuffer RAM write port, with the colour quantised to 9 bits, and also provides a full-screen clear sweep.

---
 rtl/pixel_fb_writer.sv | 177 +++++++++++++++++
 tb/tb_pixel_fb_writer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fb_writer.sv
// pixel_fb_writer: clips incoming pixel writes, buffers them in a small FIFO and
// drains them into the framebuffer write port; also runs a full-screen clear sweep.
module pixel_fb_writer #(
    parameter int unsigned WIDTH      = 160,
    parameter int unsigned HEIGHT     = 120,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        draw_enable,
    input  logic [7:0]  x_in,
    input  logic [7:0]  y_in,
    input  logic [23:0] rgb_in,
    input  logic        clear_req,
    input  logic [23:0] clear_colour,
    output logic [14:0] fb_addr,
    output logic [8:0]  fb_data,
    output logic        fb_we,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  clip_count
);

    localparam int unsigned NPIX  = WIDTH * HEIGHT;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {S_RUN, S_CLEAR} state_t;

    state_t             state_q, state_d;
    logic [14:0]        clr_cnt_q, clr_cnt_d;
    logic               clear_pending_q, clear_pending_d;
    logic [8:0]         clear_col_q, clear_col_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [14:0]        fb_addr_q, fb_addr_d;
    logic [8:0]         fb_data_q, fb_data_d;
    logic               fb_we_q, fb_we_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         clip_count_q, clip_count_d;

    logic [14:0]        mem_addr_q [FIFO_DEPTH];
    logic [8:0]         mem_data_q [FIFO_DEPTH];

    logic               in_range_c;
    logic [14:0]        pix_addr_c;
    logic [8:0]         pix_data_c;
    logic [8:0]         clr_data_c;
    logic               push_c;
    logic               pop_c;
    logic               full_c;
    logic               unused_c;

    // Coordinate clipping, linear address and 3:3:3 colour quantisation
    always_comb begin
        in_range_c = (32'(x_in) < WIDTH) && (32'(y_in) < HEIGHT);
        pix_addr_c = 15'(y_in) * 15'(WIDTH) + 15'(x_in);
        pix_data_c = {rgb_in[23:21], rgb_in[15:13], rgb_in[7:5]};
        clr_data_c = {clear_colour[23:21], clear_colour[15:13], clear_colour[7:5]};
        unused_c   = ^{rgb_in[20:16], rgb_in[12:8], rgb_in[4:0],
                       clear_colour[20:16], clear_colour[12:8], clear_colour[4:0]};
    end

    // Next-state: FIFO bookkeeping, capture counters, clear control and write port
    always_comb begin
        state_d         = state_q;
        clr_cnt_d       = clr_cnt_q;
        clear_pending_d = clear_pending_q;
        clear_col_d     = clear_col_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        fb_addr_d       = fb_addr_q;
        fb_data_d       = fb_data_q;
        fb_we_d         = 1'b0;
        overflow_d      = overflow_q;
        clip_count_d    = clip_count_q;

        full_c = (count_q == CNT_W'(FIFO_DEPTH));
        pop_c  = (state_q == S_RUN) && (count_q != '0);
        push_c = draw_enable && in_range_c && (!full_c || pop_c);

        if (draw_enable && in_range_c && full_c && !pop_c) begin
            overflow_d = 1'b1;
        end
        if (draw_enable && !in_range_c && (clip_count_q != 8'hFF)) begin
            clip_count_d = clip_count_q + 8'd1;
        end

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

        if (state_q == S_RUN) begin
            if (pop_c) begin
                fb_addr_d = mem_addr_q[rd_ptr_q];
                fb_data_d = mem_data_q[rd_ptr_q];
                fb_we_d   = 1'b1;
            end
            if (clear_pending_q && (count_q == '0)) begin
                state_d         = S_CLEAR;
                clr_cnt_d       = '0;
                clear_pending_d = 1'b0;
            end
        end else begin
            fb_addr_d = clr_cnt_q;
            fb_data_d = clear_col_q;
            fb_we_d   = 1'b1;
            clr_cnt_d = clr_cnt_q + 15'd1;
            if (clr_cnt_q == 15'(NPIX - 1)) begin
                state_d = S_RUN;
            end
        end

        // A request while busy only refreshes the colour
        if (clear_req) begin
            clear_col_d = clr_data_c;
            if (!busy) begin
                clear_pending_d = 1'b1;
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= S_RUN;
            clr_cnt_q       <= '0;
            clear_pending_q <= 1'b0;
            clear_col_q     <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            fb_addr_q       <= '0;
            fb_data_q       <= '0;
            fb_we_q         <= 1'b0;
            overflow_q      <= 1'b0;
            clip_count_q    <= '0;
        end else begin
            state_q         <= state_d;
            clr_cnt_q       <= clr_cnt_d;
            clear_pending_q <= clear_pending_d;
            clear_col_q     <= clear_col_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            fb_addr_q       <= fb_addr_d;
            fb_data_q       <= fb_data_d;
            fb_we_q         <= fb_we_d;
            overflow_q      <= overflow_d;
            clip_count_q    <= clip_count_d;
        end
    end

    // FIFO storage; validity is tracked by the pointers, so no reset is needed
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_addr_q[wr_ptr_q] <= pix_addr_c;
            mem_data_q[wr_ptr_q] <= pix_data_c;
        end
    end

    // Output drive
    always_comb begin
        fb_addr    = fb_addr_q;
        fb_data    = fb_data_q;
        fb_we      = fb_we_q;
        overflow   = overflow_q;
        clip_count = clip_count_q;
        busy       = clear_pending_q || (state_q == S_CLEAR);
    end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Self-checking bench for pixel_fb_writer against a queue-based behavioural model.
module tb_pixel_fb_writer;

    localparam int W = 160;
    localparam int H = 120;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        draw_enable = 1'b0;
    logic [7:0]  x_in = '0;
    logic [7:0]  y_in = '0;
    logic [23:0] rgb_in = '0;
    logic        clear_req = 1'b0;
    logic [23:0] clear_colour = '0;
    logic [14:0] fb_addr;
    logic [8:0]  fb_data;
    logic        fb_we;
    logic        busy;
    logic        overflow;
    logic [7:0]  clip_count;

    pixel_fb_writer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
        .clk(clk), .resetn(resetn), .draw_enable(draw_enable),
        .x_in(x_in), .y_in(y_in), .rgb_in(rgb_in),
        .clear_req(clear_req), .clear_colour(clear_colour),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
        .busy(busy), .overflow(overflow), .clip_count(clip_count)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model state
    int q_addr[$];
    int q_data[$];
    bit m_clear, m_pend, e_we, e_ovf;
    int m_sweep, m_colour, e_addr, e_data, e_clip;

    function automatic int quant(int c);
        return ((((c >> 16) & 255) / 32) * 64) + ((((c >> 8) & 255) / 32) * 8) + ((c & 255) / 32);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        q_addr.delete(); q_data.delete();
        m_clear = 0; m_pend = 0; m_sweep = 0; m_colour = 0;
        e_we = 0; e_ovf = 0; e_addr = 0; e_data = 0; e_clip = 0;
    endtask

    // One rising edge of the specified behaviour, using the inputs present at the edge
    task automatic model_edge();
        bit was_clear = m_clear;
        bit was_pend  = m_pend;
        int sz        = q_addr.size();
        int old_col   = m_colour;
        bit pop       = !was_clear && (sz > 0);
        e_we = 0;
        if (was_clear) begin
            e_we = 1; e_addr = m_sweep; e_data = old_col;
            m_sweep++;
            if (m_sweep == W * H) m_clear = 0;
        end else if (pop) begin
            e_we = 1; e_addr = q_addr.pop_front(); e_data = q_data.pop_front();
        end
        if (!was_clear && was_pend && sz == 0) begin
            m_clear = 1; m_sweep = 0; m_pend = 0;
        end
        if (clear_req) begin
            m_colour = quant(int'(clear_colour));
            if (!(was_pend || was_clear)) m_pend = 1;
        end
        if (draw_enable) begin
            if (int'(x_in) < W && int'(y_in) < H) begin
                if (sz < D || pop) begin
                    q_addr.push_back(int'(y_in) * W + int'(x_in));
                    q_data.push_back(quant(int'(rgb_in)));
                end else begin
                    e_ovf = 1;
                end
            end else if (e_clip < 255) begin
                e_clip++;
            end
        end
    endtask

    task automatic check_all();
        chk("fb_we", 32'(fb_we), 32'(e_we));
        chk("fb_addr", 32'(fb_addr), e_addr);
        chk("fb_data", 32'(fb_data), e_data);
        chk("busy", 32'(busy), 32'(m_pend | m_clear));
        chk("overflow", 32'(overflow), 32'(e_ovf));
        chk("clip_count", 32'(clip_count), e_clip);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        draw_enable = 0; clear_req = 0;
        repeat (n) step();
    endtask

    task automatic pix(input int x, input int y, input int rgb);
        draw_enable = 1; x_in = 8'(x); y_in = 8'(y); rgb_in = 24'(rgb);
        step();
        draw_enable = 0;
    endtask

    initial begin
        // Reset values
        model_reset();
        #12;
        check_all();
        resetn = 1'b1;
        idle(2);

        // Single pixel: written one cycle after capture
        pix(3, 2, 24'hFFA040);
        step();
        chk("single_addr", 32'(fb_addr), 323);
        chk("single_data", 32'(fb_data), 32'(9'b111_101_010));
        chk("single_we", 32'(fb_we), 1);
        idle(3);

        // Clipping at both edges, then saturation
        pix(160, 0, 24'h123456);
        pix(0, 120, 24'h654321);
        idle(2);
        chk("clip_two", 32'(clip_count), 2);
        chk("clip_ovf", 32'(overflow), 0);
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) pix(int'($urandom_range(160, 255)), int'($urandom_range(0, 255)), int'($urandom));
            else            pix(int'($urandom_range(0, 255)), int'($urandom_range(120, 255)), int'($urandom));
        end
        idle(2);
        chk("clip_sat", 32'(clip_count), 255);

        // Back-to-back valid pixels
        for (int i = 0; i < 6; i++)
            pix(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)), int'($urandom));
        idle(3);
        chk("b2b_ovf", 32'(overflow), 0);

        // Random mixed traffic, including out-of-range coordinates
        for (int i = 0; i < 300; i++) begin
            draw_enable = 1'($urandom);
            x_in   = 8'($urandom_range(0, 175));
            y_in   = 8'($urandom_range(0, 135));
            rgb_in = 24'($urandom);
            step();
        end
        idle(3);

        // Clear requested while two pixels are in flight; pixels and a re-request mid-sweep
        pix(5, 7, int'($urandom));
        draw_enable = 1; x_in = 8'd159; y_in = 8'd119; rgb_in = 24'($urandom);
        clear_req = 1; clear_colour = 24'($urandom);
        step();
        draw_enable = 0; clear_req = 0;
        chk("busy_after_req", 32'(busy), 1);
        for (int i = 0; i < 19400; i++) begin
            if (!(m_pend || m_clear)) break;
            draw_enable = 0; clear_req = 0;
            if (m_clear && m_sweep >= 9000 && m_sweep < 9006) begin
                draw_enable = 1;
                x_in   = 8'($urandom_range(0, W - 1));
                y_in   = 8'($urandom_range(0, H - 1));
                rgb_in = 24'($urandom);
            end
            if (m_clear && m_sweep == 12000) begin
                clear_req = 1; clear_colour = 24'($urandom);
            end
            step();
        end
        chk("sweep_done", 32'(busy), 0);
        idle(6);
        chk("clear_ovf", 32'(overflow), 1);

        // Reset in the middle of a sweep
        clear_req = 1; clear_colour = 24'hFFFFFF;
        step();
        clear_req = 0;
        for (int i = 0; i < 6000; i++) begin
            if (m_clear && m_sweep >= 5000) break;
            step();
        end
        chk("sweep_reached", 32'(m_clear ? m_sweep : 0), 5000);
        #2 resetn = 1'b0;
        #1;
        chk("rst_we", 32'(fb_we), 0);
        chk("rst_addr", 32'(fb_addr), 0);
        chk("rst_data", 32'(fb_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_clip", 32'(clip_count), 0);
        model_reset();
        #3 resetn = 1'b1;
        idle(2);
        pix(10, 20, 24'h00FF00);
        step();
        chk("post_rst_addr", 32'(fb_addr), 3210);
        idle(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
